// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one uart_tx serializer
// between N byte-wide debug/trace requesters.
//
// Optional feature macro: UART_ARB_SRC_TAG_EN. When defined, every granted
// byte is preceded by a tag byte 8'h30+grant_id sent as a full transfer.
//
// Ports:
//   clk, reset   system clock, asynchronous active-high reset
//   req_valid    [N]     requester i has a byte pending
//   req_byte     [8*N]   byte of requester i at [8i+7:8i]
//   req_ready    [N]     one-cycle capture pulse to the granted requester
//   uart_valid           data_valid to uart_tx
//   uart_byte    [8]     byte to uart_tx, stable from LOAD until IDLE
//   uart_busy            busy from uart_tx
//   grant_id     [IDW]   index of the requester being served
//   active               high in every state except IDLE
//   err_timeout          one-cycle pulse when a START timeout aborts a transfer
module uart_tx_arbiter #(
  parameter int unsigned N             = 4,
  parameter int unsigned IDW           = 2,
  parameter int unsigned START_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req_valid,
  input  logic [8*N-1:0]   req_byte,
  output logic [N-1:0]     req_ready,
  output logic             uart_valid,
  output logic [7:0]       uart_byte,
  input  logic             uart_busy,
  output logic [IDW-1:0]   grant_id,
  output logic             active,
  output logic             err_timeout
);

  localparam int unsigned CNTW = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DRAIN,
    S_GAP
  } state_t;

  state_t          r_state;
  logic [IDW-1:0]  r_last;
  logic [IDW-1:0]  r_grant;
  logic [CNTW-1:0] r_cnt;
  logic [N-1:0]    r_req_ready;
  logic            r_uart_valid;
  logic [7:0]      r_uart_byte;
  logic            r_active;
  logic            r_err;
`ifdef UART_ARB_SRC_TAG_EN
  logic            r_tag_phase;
  logic [7:0]      r_data;
`endif

  logic [7:0]      w_byte [N];
  logic            w_pick_vld;
  logic [IDW-1:0]  w_pick_id;

  // Unpack the flat request byte bus into one byte per requester.
  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign w_byte[gi] = req_byte[8*gi +: 8];
  end

  // Round-robin pick: first valid requester after r_last, wrapping. Offsets are
  // scanned from farthest to nearest so the nearest valid one wins.
  always_comb begin
    int unsigned idx;
    w_pick_vld = 1'b0;
    w_pick_id  = '0;
    idx        = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (32'(r_last) + 32'(k)) % N;
      if (req_valid[IDW'(idx)]) begin
        w_pick_vld = 1'b1;
        w_pick_id  = IDW'(idx);
      end
    end
  end

  // Transfer sequencer: IDLE -> LOAD -> START -> DRAIN -> GAP -> IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last       <= IDW'(N - 1);
      r_grant      <= '0;
      r_cnt        <= '0;
      r_req_ready  <= '0;
      r_uart_valid <= 1'b0;
      r_uart_byte  <= '0;
      r_active     <= 1'b0;
      r_err        <= 1'b0;
`ifdef UART_ARB_SRC_TAG_EN
      r_tag_phase  <= 1'b0;
      r_data       <= '0;
`endif
    end else begin
      r_req_ready <= '0;
      r_err       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pick_vld) begin
            r_grant  <= w_pick_id;
            r_last   <= w_pick_id;
            r_active <= 1'b1;
            r_state  <= S_LOAD;
`ifdef UART_ARB_SRC_TAG_EN
            // Tag goes first; the data byte is held until the tag has drained.
            r_uart_byte <= 8'h30 + 8'(w_pick_id);
            r_data      <= w_byte[w_pick_id];
            r_tag_phase <= 1'b1;
`else
            r_uart_byte <= w_byte[w_pick_id];
            r_req_ready <= N'(1) << w_pick_id;
`endif
          end
        end
        S_LOAD: begin
          r_uart_valid <= 1'b1;
          r_cnt        <= '0;
          r_state      <= S_START;
        end
        S_START: begin
          // busy already high on entry is accepted as the start edge
          if (uart_busy) begin
            r_uart_valid <= 1'b0;
            r_state      <= S_DRAIN;
          end else if (r_cnt == CNTW'(START_TIMEOUT - 1)) begin
            r_uart_valid <= 1'b0;
            r_err        <= 1'b1;
            r_state      <= S_GAP;
`ifdef UART_ARB_SRC_TAG_EN
            // Abort both bytes but release the requester so it cannot hang.
            if (r_tag_phase) begin
              r_tag_phase <= 1'b0;
              r_req_ready <= N'(1) << r_grant;
            end
`endif
          end else begin
            r_cnt <= r_cnt + CNTW'(1);
          end
        end
        S_DRAIN: begin
          if (!uart_busy) r_state <= S_GAP;
        end
        S_GAP: begin
`ifdef UART_ARB_SRC_TAG_EN
          if (r_tag_phase) begin
            r_tag_phase <= 1'b0;
            r_uart_byte <= r_data;
            r_req_ready <= N'(1) << r_grant;
            r_state     <= S_LOAD;
          end else begin
            r_active <= 1'b0;
            r_state  <= S_IDLE;
          end
`else
          r_active <= 1'b0;
          r_state  <= S_IDLE;
`endif
        end
        default: begin
          r_active <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign uart_valid  = r_uart_valid;
  assign uart_byte   = r_uart_byte;
  assign grant_id    = r_grant;
  assign active      = r_active;
  assign err_timeout = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed stimulus with a scoreboard for uart_tx_arbiter.
// Expected UART bytes and req_ready pulses are queued by the stimulus and
// checked by an independent monitor.
module tb_uart_tx_arbiter;

  localparam int unsigned N    = 4;
  localparam int unsigned IDW  = 2;
  localparam int unsigned TO   = 8;
  localparam int          VLEN = 3;   // uart_valid cycles with the busy model
`ifdef UART_ARB_SRC_TAG_EN
  localparam int          LAT  = 16;  // request to data-byte req_ready
`else
  localparam int          LAT  = 1;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_byte;
  logic [N-1:0]   req_ready;
  logic           uart_valid;
  logic [7:0]     uart_byte;
  logic           uart_busy;
  logic [IDW-1:0] grant_id;
  logic           active;
  logic           err_timeout;

  typedef struct {
    logic [IDW-1:0] id;
    logic [7:0]     b;
    int             vlen;
  } xfer_t;

  xfer_t uq[$];
  int    rq[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    err_cnt  = 0;
  bit    busy_en  = 1'b1;

  uart_tx_arbiter #(.N(N), .IDW(IDW), .START_TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_byte    (req_byte),
    .req_ready   (req_ready),
    .uart_valid  (uart_valid),
    .uart_byte   (uart_byte),
    .uart_busy   (uart_busy),
    .grant_id    (grant_id),
    .active      (active),
    .err_timeout (err_timeout)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_xfer(input int id, input logic [7:0] b);
`ifdef UART_ARB_SRC_TAG_EN
    uq.push_back('{IDW'(id), 8'h30 + 8'(id), VLEN});
`endif
    uq.push_back('{IDW'(id), b, VLEN});
    rq.push_back(id);
  endtask

  task automatic push_timeout(input int id, input logic [7:0] b);
`ifdef UART_ARB_SRC_TAG_EN
    uq.push_back('{IDW'(id), 8'h30 + 8'(id), int'(TO)});
`else
    uq.push_back('{IDW'(id), b, int'(TO)});
`endif
    rq.push_back(id);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_uart_valid"}, 32'(uart_valid), 32'd0);
    chk({tag, "_uart_byte"},  32'(uart_byte),  32'd0);
    chk({tag, "_req_ready"},  32'(req_ready),  32'd0);
    chk({tag, "_grant_id"},   32'(grant_id),   32'd0);
    chk({tag, "_active"},     32'(active),     32'd0);
    chk({tag, "_err"},        32'(err_timeout), 32'd0);
  endtask

  task automatic wait_ready(output int idx, output int cyc);
    idx = -1;
    cyc = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        cyc = c;
        for (int i = 0; i < int'(N); i++) if (req_ready[i]) idx = i;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL ready_timeout: got no req_ready expected a pulse within 300 cycles");
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!active) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL idle_timeout: got active=1 expected 0 within 300 cycles");
  endtask

  task automatic wait_valid_fall();
    bit seen = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (uart_valid) seen = 1'b1;
      else if (seen) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL valid_fall_timeout: got no uart_valid fall expected one within 300 cycles");
  endtask

  // uart_tx busy model: busy rises 2 cycles after uart_valid, stays 10 cycles.
  initial begin
    int dly;
    int bcnt;
    dly = 0;
    bcnt = 0;
    uart_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (reset || !busy_en) begin
        uart_busy = 1'b0;
        dly = 0;
        bcnt = 0;
      end else if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) uart_busy = 1'b0;
      end else if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          uart_busy = 1'b1;
          bcnt = 10;
        end
      end else if (uart_valid && !uart_busy) begin
        dly = 2;
      end
    end
  end

  // Monitor: pops expectations on each req_ready pulse and uart_valid pulse.
  initial begin
    logic  pv;
    int    cnt;
    int    ev;
    int    id;
    xfer_t e;
    pv = 1'b0;
    cnt = 0;
    ev = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pv = 1'b0;
      end else begin
        if (err_timeout) err_cnt++;
        if (req_ready != '0) begin
          if (rq.size() == 0) begin
            chk("ready_unexpected", 32'(req_ready), 32'd0);
          end else begin
            id = rq.pop_front();
            chk("ready_vec", 32'(req_ready), 32'(1) << id);
          end
        end
        if (uart_valid && !pv) begin
          if (uq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL uart_unexpected: got byte %0h expected no transfer", uart_byte);
            ev = 0;
          end else begin
            e = uq.pop_front();
            chk("uart_byte", 32'(uart_byte), 32'(e.b));
            chk("uart_grant", 32'(grant_id), 32'(e.id));
            ev = e.vlen;
          end
          cnt = 1;
        end else if (uart_valid) begin
          cnt++;
        end else if (pv) begin
          chk("valid_len", 32'(cnt), 32'(ev));
        end
        pv = uart_valid;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1);
  end

  initial begin
    int idx;
    int cyc;
    reset = 1'b1;
    req_valid = '0;
    req_byte = '0;
    repeat (3) @(negedge clk);
    check_reset("rst0");
    reset = 1'b0;
    @(negedge clk);

    // Single requester 0 with "H".
    req_byte[7:0] = 8'h48;
    push_xfer(0, 8'h48);
    req_valid = 4'b0001;
    wait_ready(idx, cyc);
    chk("t1_idx", 32'(idx), 32'd0);
    chk("t1_latency", 32'(cyc), 32'(LAT));
    chk("t1_active", 32'(active), 32'd1);
    req_valid = '0;
    @(negedge clk);
    chk("t1_uart_valid", 32'(uart_valid), 32'd1);
    wait_idle();
    chk("t1_idle", 32'(active), 32'd0);

    // Reset so the round-robin pointer starts at requester 0 again.
    reset = 1'b1;
    #1;
    check_reset("rst1");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // All four continuously valid: grants 0,1,2,3,0.
    req_byte = {8'h44, 8'h43, 8'h42, 8'h41};
    for (int i = 0; i < 5; i++) push_xfer(i % 4, 8'h41 + 8'(i % 4));
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_ready(idx, cyc);
      chk("t2_grant", 32'(idx), 32'(i % 4));
    end
    req_valid = '0;
    wait_idle();

    // START timeout with busy tied low.
    busy_en = 1'b0;
    req_byte[7:0] = 8'h54;
    push_timeout(0, 8'h54);
    req_valid = 4'b0001;
    wait_ready(idx, cyc);
    chk("t3_idx", 32'(idx), 32'd0);
    req_valid = '0;
    for (int c = 0; c < 50; c++) begin
      if (err_timeout) break;
      @(negedge clk);
    end
    chk("t3_err", 32'(err_timeout), 32'd1);
    chk("t3_active_gap", 32'(active), 32'd1);
    @(negedge clk);
    chk("t3_active_idle", 32'(active), 32'd0);
    chk("t3_err_once", 32'(err_timeout), 32'd0);
    chk("t3_err_cnt", 32'(err_cnt), 32'd1);
    busy_en = 1'b1;
    @(negedge clk);

    // Reset during DRAIN with requester 1 valid, then re-grant after release.
    req_byte[15:8] = 8'h52;
    push_xfer(1, 8'h52);
    req_valid = 4'b0010;
    wait_ready(idx, cyc);
    chk("t4_idx", 32'(idx), 32'd1);
    wait_valid_fall();
    chk("t4_drain_busy", 32'(uart_busy), 32'd1);
    reset = 1'b1;
    #1;
    check_reset("rst2");
    repeat (2) @(negedge clk);
    push_xfer(1, 8'h52);
    reset = 1'b0;
    wait_ready(idx, cyc);
    chk("t4_regrant", 32'(idx), 32'd1);
    req_valid = '0;
    wait_idle();

    // Requester 2 drops while 0 is served; 3 stays valid and wins next.
    req_byte = {8'h64, 8'h63, 8'h62, 8'h61};
    push_xfer(0, 8'h61);
    req_valid = 4'b0001;
    wait_ready(idx, cyc);
    chk("t5_first", 32'(idx), 32'd0);
    push_xfer(3, 8'h64);
    req_valid = 4'b1100;
    repeat (3) @(negedge clk);
    req_valid = 4'b1000;
    wait_ready(idx, cyc);
    chk("t5_next", 32'(idx), 32'd3);
    req_valid = '0;
    wait_idle();

    // Requester 1 sends "C" (preceded by tag 8'h31 when tagging is built in).
    req_byte[15:8] = 8'h43;
    push_xfer(1, 8'h43);
    req_valid = 4'b0010;
    wait_ready(idx, cyc);
    chk("t6_idx", 32'(idx), 32'd1);
    req_valid = '0;
    wait_idle();

    repeat (5) @(negedge clk);
    chk("uq_empty", 32'(uq.size()), 32'd0);
    chk("rq_empty", 32'(rq.size()), 32'd0);
    chk("err_total", 32'(err_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx serializer between N debug/trace requesters, e.g. halt reporter, PC tracer and bus monitor.
- Each requester offers one byte at a time with a valid/ready handshake. The arbiter grants in round-robin order and sequences the uart_tx data_valid/busy handshake.
- Sits between the debug sources and the single uart_tx instance that drives the board's serial pin.

Parameters:
- N, 4, number of requesters (2..8).
- IDW, 2, width of grant_id; must satisfy 2**IDW >= N.
- START_TIMEOUT, 255, max cycles to wait for uart_busy to rise after uart_valid asserts before aborting (1..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  N  requester i has a byte pending; held until its req_ready pulse.
- req_byte  in  8*N  byte of requester i at bits [8i+7:8i]; stable while req_valid[i].
- req_ready  out  N  one-cycle pulse: requester i's byte has been captured.
- uart_valid  out  1  to uart_tx data_valid.
- uart_byte  out  8  to uart_tx byte; stable from LOAD until return to IDLE.
- uart_busy  in  1  from uart_tx busy.
- grant_id  out  IDW  index of the requester currently being served.
- active  out  1  high in every state except IDLE.
- err_timeout  out  1  one-cycle pulse when a START timeout aborts a transfer.

Behaviour:
- Reset values: uart_valid=0, uart_byte=0, req_ready=0, grant_id=0, active=0, err_timeout=0, state=IDLE, last-grant pointer=N-1 (requester 0 wins first).
- Reset asserted mid-transfer returns to IDLE immediately. Partially sent bytes are lost and nothing is re-queued.
- States: IDLE, LOAD, START, DRAIN, GAP.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from (last+1) mod N, wrapping.
  - Latch its byte into uart_byte, set grant_id and last to that index, go to LOAD.
  - Otherwise remain in IDLE.
- LOAD (1 cycle): req_ready[grant_id]=1 for exactly this cycle; then go to START.
- START:
  - uart_valid=1.
  - When uart_busy is sampled high: uart_valid<=0, go to DRAIN.
  - If uart_busy stays low for START_TIMEOUT cycles: uart_valid<=0, err_timeout pulses for 1 cycle, go to GAP.
- DRAIN: hold until uart_busy is sampled low, then go to GAP.
- GAP (1 cycle): go to IDLE. This guarantees one idle cycle between uart_valid pulses.
- Latency: req_valid high in IDLE cycle k gives req_ready in cycle k+1 and uart_valid high in cycle k+2.
- Only one byte is in flight at a time. req_ready never pulses to more than one requester in a cycle.
- A requester that deasserts req_valid before it is granted is simply skipped; no error.
- req_valid changes while not in IDLE are ignored until the next IDLE cycle.
- Fairness: with all N requesters continuously valid, grants cycle 0,1,...,N-1,0,...
- A lone valid requester is re-granted back-to-back, one byte per transfer.
- uart_busy already high on entry to START (serializer still busy) counts as the accept edge. uart_tx must therefore deassert busy before GAP ends; it does.

Optional Feature:
- Macro UART_ARB_SRC_TAG_EN.
- Defined:
  - Every granted byte is preceded by a tag byte 8'h30+grant_id (ASCII '0'..'7') sent through the full LOAD/START/DRAIN/GAP sequence.
  - The data byte follows without re-arbitration.
  - req_ready pulses in the data byte's LOAD cycle only.
  - A timeout on the tag byte aborts both bytes but still pulses req_ready, so the requester does not hang.
- Undefined: data bytes only, exactly as described in Behaviour.

Test Plan:
- Single requester: req_valid=4'b0001, req_byte[7:0]="H", busy model rises 2 cycles after uart_valid and lasts 10 cycles.
  -> req_ready[0] one cycle after request; uart_byte=8'h48; uart_valid high until busy sampled high; active drops 1 cycle after busy falls.
- All four valid continuously with bytes "A","B","C","D".
  -> UART sees 41,42,43,44,41,... and grant_id sequence 0,1,2,3,0.
- Timeout: uart_busy tied 0, START_TIMEOUT=8.
  -> uart_valid high exactly 8 cycles; err_timeout one pulse; state returns to IDLE 1 cycle later.
- Reset asserted during DRAIN with req_valid=4'b0010.
  -> all outputs 0 asynchronously; after release, requester 1 re-granted with its byte.
- Requester 2 drops req_valid while requester 0 is being served, requester 3 stays valid.
  -> next grant is 3; req_ready[2] never pulses.
- With UART_ARB_SRC_TAG_EN, requester 1 sends "C".
  -> UART sees 8'h31 then 8'h43; req_ready[1] pulses once.
